debounce_multi: RTL and testbench

- N-channel switch/button conditioner for board inputs (push-buttons, DIP switches, UART-board keys).
- Each channel has its own synchroniser, a 4-state debounce FSM and a debounce counter.
- Outputs per channel: level, rise/fall ticks, and a hold tick with optional auto-repeat.
- A shared clock-enable (ce) sets the debounce time base, so millisecond debounce needs no wide counters.

---
 rtl/debounce_multi.sv | 274 +++++++++++++++++++++++++++
 tb/tb_debounce_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// Conditions CHANNELS board-level switch or button inputs. Each channel has:
//   * a SYNC_STAGES-deep synchroniser that runs every clk,
//   * a four-state debounce FSM (ZERO / WAIT1 / ONE / WAIT0) with its own
//     down-counter, advancing only on ce-qualified cycles,
//   * a hold / auto-repeat timer that produces hold_tick while the debounced
//     level stays high after an accepted press.
// The shared ce input is the debounce time base. With ce tied high everything
// runs per clk. With ce as a slow strobe, millisecond debounce times need only
// narrow counters.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   ce         in   time-base enable for the FSMs and counters
//   sw_in      in   [CHANNELS] raw asynchronous switch inputs
//   db_level   out  [CHANNELS] debounced level (registered)
//   rise_tick  out  [CHANNELS] one-clk pulse on an accepted 0->1
//   fall_tick  out  [CHANNELS] one-clk pulse on an accepted 1->0
//   hold_tick  out  [CHANNELS] one-clk pulse on hold / repeat events
//   any_tick   out  OR of every rise_tick and fall_tick, same clk as they are
// -----------------------------------------------------------------------------
module debounce_multi #(
  parameter int                     CHANNELS      = 4,
  parameter int                     SYNC_STAGES   = 2,
  parameter int                     DB_CYCLES     = 1023,
  parameter int                     HOLD_CYCLES   = 0,
  parameter int                     REPEAT_CYCLES = 0,
  parameter logic [CHANNELS-1:0]    INIT_LEVEL    = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic [CHANNELS-1:0] sw_in,
  output logic [CHANNELS-1:0] db_level,
  output logic [CHANNELS-1:0] rise_tick,
  output logic [CHANNELS-1:0] fall_tick,
  output logic [CHANNELS-1:0] hold_tick,
  output logic                any_tick
);

  // Debounce counter wide enough to hold DB_CYCLES.
  localparam int CNT_W = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);

  // The hold timer counts 0 .. N-1 for both the initial hold and the repeat
  // interval, so it only needs to represent the larger of the two minus one.
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HCNT_W   = (HOLD_MAX <= 2) ? 1 : $clog2(HOLD_MAX);

  localparam int HOLD_LAST_I = (HOLD_CYCLES   > 0) ? HOLD_CYCLES   - 1 : 0;
  localparam int REP_LAST_I  = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0]  DB_LOAD   = CNT_W'(DB_CYCLES);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_LAST_I);
  localparam logic [HCNT_W-1:0] REP_LAST  = HCNT_W'(REP_LAST_I);

  // Debounce FSM encoding. Bit 1 is the debounced level of the state, so
  // ONE and WAIT0 read as 1 and ZERO and WAIT1 read as 0.
  localparam logic [1:0] ST_ZERO  = 2'b00;
  localparam logic [1:0] ST_WAIT1 = 2'b01;
  localparam logic [1:0] ST_ONE   = 2'b11;
  localparam logic [1:0] ST_WAIT0 = 2'b10;

  // Hold timer phases: idle (not armed or finished), initial hold, repeat.
  localparam logic [1:0] HP_IDLE = 2'b00;
  localparam logic [1:0] HP_HOLD = 2'b01;
  localparam logic [1:0] HP_REP  = 2'b10;

  // Phase entered on an accepted press, and phase entered after the first
  // hold_tick. With HOLD_CYCLES = 0 the timer is never armed.
  localparam logic [1:0] HP_ARM        = (HOLD_CYCLES   > 0) ? HP_HOLD : HP_IDLE;
  localparam logic [1:0] HP_AFTER_HOLD = (REPEAT_CYCLES > 0) ? HP_REP  : HP_IDLE;

  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] w_sync_s;
  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] w_rise_ev;
  logic [CHANNELS-1:0] w_fall_ev;
  logic [CHANNELS-1:0] w_hold_ev;

  logic [CHANNELS-1:0] r_db_level;
  logic [CHANNELS-1:0] r_rise_tick;
  logic [CHANNELS-1:0] r_fall_tick;
  logic [CHANNELS-1:0] r_hold_tick;
  logic                r_any_tick;

  // Input synchroniser chain, free-running on every clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= INIT_LEVEL;
      end
    end else begin
      r_sync[0] <= sw_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_sync_s = r_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_hphase;
    logic [HCNT_W-1:0] r_hcnt;
    logic              r_rise_ev;
    logic              r_fall_ev;
    logic              r_hold_ev;

    logic [1:0]        w_state_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [CNT_W-1:0]  w_cnt_dec;
    logic [1:0]        w_hphase_nx;
    logic [HCNT_W-1:0] w_hcnt_nx;
    logic              w_rise_nx;
    logic              w_fall_nx;
    logic              w_hold_nx;

    assign w_cnt_dec = r_cnt - CNT_W'(1);

    // Next-state, counter and event logic for one channel.
    always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_hphase_nx = r_hphase;
      w_hcnt_nx   = r_hcnt;
      w_rise_nx   = 1'b0;
      w_fall_nx   = 1'b0;
      w_hold_nx   = 1'b0;
      if (ce) begin
        case (r_state)
          ST_ZERO: begin
            w_hphase_nx = HP_IDLE;
            w_hcnt_nx   = {HCNT_W{1'b0}};
            if (w_sync_s[g]) begin
              w_state_nx = ST_WAIT1;
              w_cnt_nx   = DB_LOAD;
            end else begin
              w_state_nx = ST_ZERO;
            end
          end
          ST_WAIT1: begin
            if (!w_sync_s[g]) begin
              // Input dropped before the count expired: a glitch, no tick.
              w_state_nx = ST_ZERO;
              w_cnt_nx   = {CNT_W{1'b0}};
            end else if (w_cnt_dec == {CNT_W{1'b0}}) begin
              w_state_nx  = ST_ONE;
              w_cnt_nx    = {CNT_W{1'b0}};
              w_rise_nx   = 1'b1;
              w_hphase_nx = HP_ARM;
              w_hcnt_nx   = {HCNT_W{1'b0}};
            end else begin
              w_cnt_nx = w_cnt_dec;
            end
          end
          ST_ONE: begin
            // The hold timer only runs after an accepted press; the level
            // loaded by reset never arms it.
            case (r_hphase)
              HP_HOLD: begin
                if (r_hcnt == HOLD_LAST) begin
                  w_hold_nx   = 1'b1;
                  w_hcnt_nx   = {HCNT_W{1'b0}};
                  w_hphase_nx = HP_AFTER_HOLD;
                end else begin
                  w_hcnt_nx = r_hcnt + HCNT_W'(1);
                end
              end
              HP_REP: begin
                if (r_hcnt == REP_LAST) begin
                  w_hold_nx = 1'b1;
                  w_hcnt_nx = {HCNT_W{1'b0}};
                end else begin
                  w_hcnt_nx = r_hcnt + HCNT_W'(1);
                end
              end
              default: begin
                w_hphase_nx = HP_IDLE;
                w_hcnt_nx   = {HCNT_W{1'b0}};
              end
            endcase
            if (!w_sync_s[g]) begin
              w_state_nx = ST_WAIT0;
              w_cnt_nx   = DB_LOAD;
            end else begin
              w_state_nx = ST_ONE;
            end
          end
          ST_WAIT0: begin
            // Hold timer is left untouched here, so a rejected release glitch
            // resumes the hold / repeat cadence where it stopped.
            if (w_sync_s[g]) begin
              w_state_nx = ST_ONE;
              w_cnt_nx   = {CNT_W{1'b0}};
            end else if (w_cnt_dec == {CNT_W{1'b0}}) begin
              w_state_nx  = ST_ZERO;
              w_cnt_nx    = {CNT_W{1'b0}};
              w_fall_nx   = 1'b1;
              w_hphase_nx = HP_IDLE;
              w_hcnt_nx   = {HCNT_W{1'b0}};
            end else begin
              w_cnt_nx = w_cnt_dec;
            end
          end
          default: begin
            w_state_nx  = ST_ZERO;
            w_cnt_nx    = {CNT_W{1'b0}};
            w_hphase_nx = HP_IDLE;
            w_hcnt_nx   = {HCNT_W{1'b0}};
          end
        endcase
      end else begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
      end
    end

    // Channel state, counters and one-clk event flags.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state   <= INIT_LEVEL[g] ? ST_ONE : ST_ZERO;
        r_cnt     <= {CNT_W{1'b0}};
        r_hphase  <= HP_IDLE;
        r_hcnt    <= {HCNT_W{1'b0}};
        r_rise_ev <= 1'b0;
        r_fall_ev <= 1'b0;
        r_hold_ev <= 1'b0;
      end else begin
        r_state   <= w_state_nx;
        r_cnt     <= w_cnt_nx;
        r_hphase  <= w_hphase_nx;
        r_hcnt    <= w_hcnt_nx;
        r_rise_ev <= w_rise_nx;
        r_fall_ev <= w_fall_nx;
        r_hold_ev <= w_hold_nx;
      end
    end

    assign w_level[g]   = r_state[1];
    assign w_rise_ev[g] = r_rise_ev;
    assign w_fall_ev[g] = r_fall_ev;
    assign w_hold_ev[g] = r_hold_ev;
  end

  // Output register stage: level and ticks leave together, one clk after the
  // state that produced them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_level  <= INIT_LEVEL;
      r_rise_tick <= {CHANNELS{1'b0}};
      r_fall_tick <= {CHANNELS{1'b0}};
      r_hold_tick <= {CHANNELS{1'b0}};
      r_any_tick  <= 1'b0;
    end else begin
      r_db_level  <= w_level;
      r_rise_tick <= w_rise_ev;
      r_fall_tick <= w_fall_ev;
      r_hold_tick <= w_hold_ev;
      r_any_tick  <= |(w_rise_ev | w_fall_ev);
    end
  end

  assign db_level  = r_db_level;
  assign rise_tick = r_rise_tick;
  assign fall_tick = r_fall_tick;
  assign hold_tick = r_hold_tick;
  assign any_tick  = r_any_tick;

endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;

  localparam int         CH   = 4;
  localparam int         DB   = 4;
  localparam int         HOLD = 10;
  localparam int         REP  = 3;
  localparam logic [3:0] INIT = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic [3:0] sw_in;
  logic [3:0] db_level, rise_tick, fall_tick, hold_tick;
  logic       any_tick;

  debounce_multi #(
    .CHANNELS(4), .SYNC_STAGES(2), .DB_CYCLES(4),
    .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .INIT_LEVEL(4'b1000)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .sw_in(sw_in),
    .db_level(db_level), .rise_tick(rise_tick), .fall_tick(fall_tick),
    .hold_tick(hold_tick), .any_tick(any_tick)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: accepted level per channel, length of the current run of
  // ce cycles that disagreed with it, press age for hold/repeat timing.
  logic [3:0] m_lvl;
  int         m_run [CH];
  bit         m_armed [CH];
  int         m_age [CH];
  logic [3:0] m_sh0, m_sh1;  // input as seen through the two-flop delay
  logic [3:0] p_rise, p_fall, p_hold;
  logic [3:0] e_lvl, e_rise, e_fall, e_hold;
  logic       e_any;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_lvl = INIT;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_armed[c] = 1'b0; m_age[c] = 0;
    end
    m_sh0 = INIT; m_sh1 = INIT;
    p_rise = 4'b0000; p_fall = 4'b0000; p_hold = 4'b0000;
    e_lvl = INIT; e_rise = 4'b0000; e_fall = 4'b0000; e_hold = 4'b0000; e_any = 1'b0;
  endtask

  // One clock edge of the reference: outputs show what was decided last edge.
  task automatic model_step(input logic [3:0] sw, input logic c_en);
    logic [3:0] s;
    s = m_sh1;
    e_lvl  = m_lvl;
    e_rise = p_rise; e_fall = p_fall; e_hold = p_hold;
    e_any  = |(p_rise | p_fall);
    p_rise = 4'b0000; p_fall = 4'b0000; p_hold = 4'b0000;
    if (c_en) begin
      for (int c = 0; c < CH; c++) begin
        if (m_lvl[c] && m_run[c] == 0 && m_armed[c]) begin
          m_age[c]++;
          if (m_age[c] == HOLD || (REP > 0 && m_age[c] > HOLD && (m_age[c] - HOLD) % REP == 0))
            p_hold[c] = 1'b1;
        end
        if (s[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            m_lvl[c] = s[c];
            m_run[c] = 0;
            m_age[c] = 0;
            m_armed[c] = s[c];
            if (s[c]) p_rise[c] = 1'b1;
            else p_fall[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
    m_sh1 = m_sh0;
    m_sh0 = sw;
  endtask

  // Drive one cycle from a falling edge, model the rising edge, compare at the next falling edge.
  task automatic cyc(input logic [3:0] sw, input logic c_en);
    sw_in = sw;
    ce    = c_en;
    @(posedge clk);
    model_step(sw, c_en);
    @(negedge clk);
    check_eq("db_level",  {28'd0, db_level},  {28'd0, e_lvl});
    check_eq("rise_tick", {28'd0, rise_tick}, {28'd0, e_rise});
    check_eq("fall_tick", {28'd0, fall_tick}, {28'd0, e_fall});
    check_eq("hold_tick", {28'd0, hold_tick}, {28'd0, e_hold});
    check_eq("any_tick",  {31'd0, any_tick},  {31'd0, e_any});
  endtask

  // Assert reset asynchronously at a falling edge and hold it for two clocks.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("rst_level", {28'd0, db_level}, {28'd0, INIT});
    check_eq("rst_ticks", {15'd0, rise_tick, fall_tick, hold_tick, any_tick}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] seen;
    logic [3:0] sw_r;
    int lat, rise_at, nh, first_h, second_h, late_h, width;

    reset = 1'b1; ce = 1'b1; sw_in = INIT;
    model_reset();
    @(negedge clk);
    apply_reset();

    // 1: idle at the reset level produces no ticks
    seen = 4'b0000;
    repeat (50) begin
      cyc(4'b1000, 1'b1);
      seen = seen | rise_tick | fall_tick | hold_tick | {3'b000, any_tick};
    end
    check_eq("idle_no_ticks", {28'd0, seen}, 32'd0);

    // 2: clean press and release on ch0
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      cyc(4'b1001, 1'b1);
      if (rise_tick[0] && lat < 0) lat = i;
    end
    check_eq("rise_latency", lat, 8);
    repeat (5) cyc(4'b1001, 1'b1);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      cyc(4'b1000, 1'b1);
      if (fall_tick[0] && lat < 0) lat = i;
    end
    check_eq("fall_latency", lat, 8);

    // 3: glitch on ch1 rejected, then a just-long-enough pulse accepted
    seen = 4'b0000;
    repeat (4) cyc(4'b1010, 1'b1);
    repeat (15) begin
      cyc(4'b1000, 1'b1);
      seen = seen | rise_tick | fall_tick;
    end
    check_eq("glitch_level", {31'd0, db_level[1]}, 32'd0);
    check_eq("glitch_ticks", {28'd0, seen}, 32'd0);
    seen = 4'b0000;
    repeat (5) cyc(4'b1010, 1'b1);
    repeat (12) begin
      cyc(4'b1000, 1'b1);
      seen = seen | rise_tick;
    end
    check_eq("accept5_rise", {28'd0, seen}, 32'h2);

    // 4: hold and repeat on ch2
    rise_at = -1; nh = 0; first_h = -1; second_h = -1; late_h = 0;
    for (int i = 1; i <= 45; i++) begin
      cyc((i <= 30) ? 4'b1100 : 4'b1000, 1'b1);
      if (rise_tick[2]) rise_at = i;
      if (hold_tick[2]) begin
        nh++;
        if (first_h < 0) first_h = i;
        else if (second_h < 0) second_h = i;
        if (!db_level[2]) late_h++;
      end
    end
    check_eq("hold_first", first_h - rise_at, 10);
    check_eq("hold_repeat", second_h - first_h, 3);
    check_eq("hold_count", nh, 6);
    check_eq("hold_after_fall", late_h, 0);

    // 5: ce strobe every 4th clk on ch0
    rise_at = -1; width = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(4'b1001, (i % 4) == 0);
      if (rise_tick[0]) begin
        width++;
        if (rise_at < 0) rise_at = i;
      end
    end
    check_eq("ce_latency", rise_at, 21);
    check_eq("ce_tick_width", width, 1);
    repeat (12) cyc(4'b1000, 1'b1);

    // 6: reset during WAIT1 on ch0 while ch3 sits in ONE, then a joint press
    repeat (4) cyc(4'b1001, 1'b1);
    apply_reset();
    seen = 4'b0000;
    repeat (20) begin
      cyc(4'b1000, 1'b1);
      seen = seen | rise_tick | fall_tick | hold_tick;
    end
    check_eq("post_rst_ticks", {28'd0, seen}, 32'd0);
    repeat (8) cyc(4'b1011, 1'b1);
    check_eq("joint_rise", {28'd0, rise_tick}, 32'h3);
    check_eq("joint_any", {31'd0, any_tick}, 32'd1);
    repeat (20) cyc(4'b1000, 1'b1);

    // 7: randomized traffic against the model
    sw_r = 4'b1000;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 11) == 0) sw_r[c] = ~sw_r[c];
      end
      if ($urandom_range(0, 699) == 0) begin
        sw_in = sw_r;
        apply_reset();
      end
      cyc(sw_r, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
